text_grid_ctrl: RTL and testbench

- Parametrised character-grid controller between the keyboard/editor write path, the VGA scan counters and an external single-port character RAM.
- Tracks which cells hold text in an occupancy bitmap and arbitrates the RAM port between writes, a full-clear sweep, a single-row clear sweep and display reads.
- Adds a circular top-row pointer, so a scroll costs one row clear instead of moving data.
- Accepts writes through a ready/valid handshake.

---
 rtl/text_pkg.sv | 26 ++
 rtl/row_map.sv | 22 ++
 rtl/text_grid_ctrl.sv | 175 +++++++++++++++++
 tb/tb_text_grid_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// ============================================================================
// text_pkg : shared FSM state encoding, default grid geometry, row-wrap helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package text_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWEEP_ALL = 2'd1,
    SWEEP_ROW = 2'd2
  } state_e;

  localparam int COLS_DEFAULT      = 20;
  localparam int ROWS_DEFAULT      = 15;
  localparam int CELL_LOG2_DEFAULT = 5;

  // Inputs are both < rows, so a single conditional subtract replaces a modulo.
  function automatic int wrap_row(input int sum, input int rows);
    return (sum >= rows) ? (sum - rows) : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_map.sv
// ============================================================================
// row_map : logical-to-physical row translation for the circular top-row pointer
// Revision : 1.0
// ============================================================================
`default_nettype none

module row_map
  import text_pkg::*;
#(
  parameter int ROWS  = ROWS_DEFAULT,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic [ROW_W-1:0] logical_i,
  input  logic [ROW_W-1:0] top_i,
  output logic [ROW_W-1:0] phys_o
);

  assign phys_o = ROW_W'(wrap_row(32'(logical_i) + 32'(top_i), ROWS));

endmodule

`default_nettype wire

// File: rtl/text_grid_ctrl.sv
// ============================================================================
// text_grid_ctrl : character-grid RAM arbiter with occupancy bitmap and scrolling
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_grid_ctrl
  import text_pkg::*;
#(
  parameter int COLS      = COLS_DEFAULT,
  parameter int ROWS      = ROWS_DEFAULT,
  parameter int CELL_LOG2 = CELL_LOG2_DEFAULT,
  parameter int DATA_W    = 8,
  localparam int COL_W    = $clog2(COLS),
  localparam int ROW_W    = $clog2(ROWS),
  localparam int RAM_AW   = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [8:0]        v_cnt,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_erase,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              clear_req,
  input  logic              scroll_req,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              enable_word_display,
  output logic [ROW_W-1:0]  top_row
);

  localparam logic [RAM_AW-1:0] SWEEP_ALL_LAST = RAM_AW'(ROWS * (2 ** COL_W) - 1);
  localparam logic [RAM_AW-1:0] SWEEP_ROW_LAST = RAM_AW'(COLS - 1);

  state_e                      state_q, state_d;
  logic [RAM_AW-1:0]           cnt_q, cnt_d;
  logic [ROW_W-1:0]            top_q, top_d;
  logic [ROW_W-1:0]            sweep_row_q, sweep_row_d;
  logic [ROWS-1:0][COLS-1:0]   bitmap_q, bitmap_d;
  logic                        ewd_q, ewd_d;

  logic [ROW_W-1:0]            w_wr_phys;
  logic                        w_wr_in_range;
  logic                        w_wr_do;
  logic [9:0]                  w_cell_col_full;
  logic [8:0]                  w_cell_row_full;
  logic [COL_W-1:0]            w_cell_col;
  logic [ROW_W-1:0]            w_cell_row;
  logic [ROW_W-1:0]            w_disp_phys;
  logic                        w_disp_in_range;

  // Write path
  row_map #(.ROWS(ROWS), .ROW_W(ROW_W)) u_wr_map (
    .logical_i (wr_row),
    .top_i     (top_q),
    .phys_o    (w_wr_phys)
  );

  assign wr_ready      = (state_q == IDLE) && !clear_req && !scroll_req;
  assign w_wr_in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign w_wr_do       = wr_valid && wr_ready && w_wr_in_range;

  // Display path
  assign w_cell_col_full = h_cnt >> CELL_LOG2;
  assign w_cell_row_full = v_cnt >> CELL_LOG2;
  assign w_disp_in_range = (32'(w_cell_col_full) < COLS) && (32'(w_cell_row_full) < ROWS);
  assign w_cell_col      = w_cell_col_full[COL_W-1:0];
  assign w_cell_row      = w_cell_row_full[ROW_W-1:0];

  row_map #(.ROWS(ROWS), .ROW_W(ROW_W)) u_disp_map (
    .logical_i (w_cell_row),
    .top_i     (top_q),
    .phys_o    (w_disp_phys)
  );

  // RAM port arbitration: sweeps, then writes, display read otherwise
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_addr  = {w_disp_phys, w_cell_col};
    case (state_q)
      SWEEP_ALL: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
      end
      SWEEP_ROW: begin
        ram_we   = 1'b1;
        ram_addr = {sweep_row_q, cnt_q[COL_W-1:0]};
      end
      default: begin
        if (w_wr_do) begin
          ram_we    = 1'b1;
          ram_addr  = {w_wr_phys, wr_col};
          ram_wdata = wr_erase ? '0 : wr_data;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    top_d       = top_q;
    sweep_row_d = sweep_row_q;
    bitmap_d    = bitmap_q;
    case (state_q)
      SWEEP_ALL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = IDLE;
      end
      SWEEP_ROW: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q[COL_W-1:0] == '0) state_d = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          bitmap_d = '0;
          top_d    = '0;
          cnt_d    = SWEEP_ALL_LAST;
          state_d  = SWEEP_ALL;
        end else if (scroll_req) begin
          // The old top row reappears as the new bottom row, so clear it.
          sweep_row_d       = top_q;
          bitmap_d[top_q]   = '0;
          top_d             = ROW_W'(wrap_row(32'(top_q) + 1, ROWS));
          cnt_d             = SWEEP_ROW_LAST;
          state_d           = SWEEP_ROW;
        end else if (w_wr_do) begin
          bitmap_d[w_wr_phys][wr_col] = !wr_erase;
        end
      end
      default: begin
        cnt_d   = SWEEP_ALL_LAST;
        state_d = SWEEP_ALL;
      end
    endcase
  end

  // A read stolen by a RAM write this cycle must not light the cell next cycle.
  always_comb begin
    ewd_d = 1'b0;
    if (w_disp_in_range && !ram_we) ewd_d = bitmap_q[w_disp_phys][w_cell_col];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SWEEP_ALL;
      cnt_q       <= SWEEP_ALL_LAST;
      top_q       <= '0;
      sweep_row_q <= '0;
      bitmap_q    <= '0;
      ewd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      top_q       <= top_d;
      sweep_row_q <= sweep_row_d;
      bitmap_q    <= bitmap_d;
      ewd_q       <= ewd_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign top_row             = top_q;
  assign enable_word_display = ewd_q;

endmodule

`default_nettype wire

// File: tb/tb_text_grid_ctrl.sv
// ============================================================================
// tb_text_grid_ctrl : scoreboard bench for text_grid_ctrl with default geometry
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_text_grid_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] h_cnt = 10'd700;
  logic [8:0] v_cnt = 9'd0;
  logic [3:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       wr_erase = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       clear_req = 1'b0;
  logic       scroll_req = 1'b0;
  logic       busy;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       enable_word_display;
  logic [3:0] top_row;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  int   m_top  = 0;

  text_grid_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .h_cnt               (h_cnt),
    .v_cnt               (v_cnt),
    .wr_row              (wr_row),
    .wr_col              (wr_col),
    .wr_data             (wr_data),
    .wr_erase            (wr_erase),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .clear_req           (clear_req),
    .scroll_req          (scroll_req),
    .busy                (busy),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_we              (ram_we),
    .enable_word_display (enable_word_display),
    .top_row             (top_row)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Every RAM write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en && ram_we !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL ram_write: unexpected write addr=%0d data=%0h, none expected", ram_addr, ram_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          errors++;
          $display("FAIL ram_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_sweep_all();
    for (int a = 479; a >= 0; a--) q.push_back({9'(a), 8'h00});
  endtask

  task automatic push_row_clear(input int r, input int ncols);
    for (int c = 19; c > 19 - ncols; c--) q.push_back({9'(r * 32 + c), 8'h00});
  endtask

  task automatic wait_idle(input string name, input int exp_len);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    chk(name, n, exp_len);
  endtask

  task automatic do_write(input int row, input int col, input logic [7:0] data, input logic erase);
    if (row < 15 && col < 20)
      q.push_back({9'(((row + m_top) % 15) * 32 + col), erase ? 8'h00 : data});
    wr_row   = 4'(row);
    wr_col   = 5'(col);
    wr_data  = data;
    wr_erase = erase;
    wr_valid = 1'b1;
    #1;
    chk("wr_ready_on_write", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    wr_erase = 1'b0;
  endtask

  task automatic do_scroll();
    push_row_clear(m_top, 20);
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    m_top = (m_top + 1) % 15;
    wait_idle("scroll_len", 20);
  endtask

  task automatic look(input int h, input int v, input int exp, input string name);
    h_cnt = 10'(h);
    v_cnt = 9'(v);
    tick();
    chk(name, int'(enable_word_display), exp);
  endtask

  initial begin
    // Reset held for three edges
    repeat (3) tick();
    chk("reset_busy", int'(busy), 1);
    chk("reset_wr_ready", int'(wr_ready), 0);
    chk("reset_ewd", int'(enable_word_display), 0);
    chk("reset_top", int'(top_row), 0);
    push_sweep_all();
    rst    = 1'b1;
    mon_en = 1'b1;
    wait_idle("reset_sweep_len", 480);
    chk("idle_wr_ready", int'(wr_ready), 1);

    // Row 2 col 5 -> addr 69; pixel (170,70) is that cell
    do_write(2, 5, 8'h41, 1'b0);
    h_cnt = 10'd170;
    v_cnt = 9'd70;
    #1;
    chk("disp_read_addr", int'(ram_addr), 69);
    tick();
    chk("disp_cell_2_5", int'(enable_word_display), 1);
    do_write(3, 0, 8'h42, 1'b0);
    chk("disp_stolen", int'(enable_word_display), 0);
    tick();
    chk("disp_after_steal", int'(enable_word_display), 1);
    look(650, 70, 0, "disp_col_out_of_range");
    h_cnt = 10'd700;

    // Scroll with row 0 occupied
    do_write(0, 0, 8'h55, 1'b0);
    push_row_clear(0, 20);
    scroll_req = 1'b1;
    wr_valid   = 1'b1;
    #1;
    chk("scroll_blocks_ready", int'(wr_ready), 0);
    tick();
    scroll_req = 1'b0;
    wr_valid   = 1'b0;
    m_top      = 1;
    wait_idle("scroll_len_first", 20);
    chk("top_after_scroll", int'(top_row), 1);
    do_write(0, 3, 8'h33, 1'b0);                 // phys row 1 -> addr 35
    look(0, 0, 0, "disp_scrolled_row0_col0");
    look(96, 0, 1, "disp_scrolled_row0_col3");
    look(170, 32, 1, "disp_old_row2_now_row1");

    // Thirteen more scrolls -> top_row 14
    repeat (13) do_scroll();
    chk("top_at_14", int'(top_row), 14);
    do_write(14, 0, 8'h7E, 1'b0);                // (14+14)-15 = phys 13 -> addr 416
    do_scroll();
    chk("top_wrapped", int'(top_row), 0);
    look(0, 416, 1, "disp_phys13");

    // clear_req beats a pending write; scroll during the sweep is ignored
    push_sweep_all();
    clear_req = 1'b1;
    wr_valid  = 1'b1;
    wr_row    = 4'd1;
    wr_col    = 5'd1;
    wr_data   = 8'h11;
    #1;
    chk("clear_blocks_ready", int'(wr_ready), 0);
    tick();
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    m_top     = 0;
    begin
      int n;
      n = 0;
      repeat (5) begin
        if (busy === 1'b1) n++;
        tick();
      end
      scroll_req = 1'b1;
      if (busy === 1'b1) n++;
      tick();
      scroll_req = 1'b0;
      while (busy === 1'b1 && n < 2000) begin
        n++;
        tick();
      end
      chk("clear_sweep_len", n, 480);
    end
    chk("top_after_clear", int'(top_row), 0);
    look(170, 70, 0, "disp_cleared");

    // Erase an occupied cell; out-of-range writes are accepted silently
    do_write(4, 7, 8'h99, 1'b0);                 // addr 135
    look(224, 128, 1, "disp_before_erase");
    do_write(4, 7, 8'hAA, 1'b1);
    tick();
    chk("disp_after_erase", int'(enable_word_display), 0);
    do_write(15, 0, 8'h01, 1'b0);
    do_write(0, 20, 8'h02, 1'b0);
    h_cnt = 10'd700;

    // Reset during a row sweep restarts the full sweep
    push_row_clear(0, 5);
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    repeat (5) tick();
    mon_en = 1'b0;
    rst    = 1'b0;
    repeat (2) tick();
    chk("midsweep_reset_busy", int'(busy), 1);
    push_sweep_all();
    rst    = 1'b1;
    mon_en = 1'b1;
    m_top  = 0;
    wait_idle("midsweep_reset_len", 480);
    chk("midsweep_reset_top", int'(top_row), 0);
    chk("final_wr_ready", int'(wr_ready), 1);

    tick();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
